// File: rtl/posit_decoder_param.sv
// Parametrised posit decoder with valid/ready handshakes: unpacks an N-bit posit
// into sign, regime k, exponent and hidden-bit mantissa, one regime bit per cycle.
module posit_decoder_param #(
  parameter  int N  = 32,
  parameter  int ES = 3,
  localparam int KW = $clog2(N) + 1,
  localparam int EW = (ES == 0) ? 1 : ES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  posit_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign,
  output logic [KW-1:0] k,
  output logic [EW-1:0] exp,
  output logic [N-1:0]  mantissa,
  output logic          zero,
  output logic          nar,
  output logic [2:0]    dbg_state_o
);

  // Handshakes: a word moves on the input side when in_valid && in_ready, and a
  // result moves on the output side when out_valid && out_ready, both at posedge.
  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_REGIME, S_EXP, S_FRAC, S_DONE
  } state_t;

  localparam logic [N-1:0]  NAR_W = {1'b1, {(N-1){1'b0}}};
  localparam logic [KW-1:0] ONE   = KW'(1);
  localparam logic [KW-1:0] LAST  = KW'(N - 1);

  state_t        state_q;
  logic [N-1:0]  word_q;
  logic [N-1:0]  sr_q;
  logic          pol_q;
  logic [KW-1:0] r_q;
  logic [KW-1:0] c_q;
  logic          out_valid_q;
  logic          sign_q;
  logic [KW-1:0] k_q;
  logic [EW-1:0] exp_q;
  logic [N-1:0]  mant_q;
  logic          zero_q;
  logic          nar_q;

  logic [N-1:0]  abs_w;
  logic          same;
  logic [KW-1:0] r_inc;
  logic [KW-1:0] r_fin;
  logic [KW-1:0] k_fin;
  logic          regime_end;
  logic [EW-1:0] exp_field;
  logic [N-1:0]  sr_after_exp;

  assign abs_w      = word_q[N-1] ? -word_q : word_q;
  assign same       = (sr_q[N-1] == pol_q);
  assign r_inc      = r_q + ONE;
  assign r_fin      = same ? r_inc : r_q;
  assign k_fin      = pol_q ? (r_fin - ONE) : (-r_fin);
  // A run that fills every non-sign bit ends without a terminator.
  assign regime_end = !same || ((c_q + ONE) == LAST);

  generate
    if (ES > 0) begin : g_exp
      assign exp_field    = sr_q[N-1 -: EW];
      assign sr_after_exp = sr_q << ES;
    end else begin : g_noexp
      assign exp_field    = '0;
      assign sr_after_exp = sr_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      sr_q        <= '0;
      pol_q       <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      k_q         <= '0;
      exp_q       <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            word_q  <= posit_in;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (word_q == '0) begin
            zero_q      <= 1'b1;
            nar_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (word_q == NAR_W) begin
            nar_q       <= 1'b1;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            sign_q  <= word_q[N-1];
            word_q  <= abs_w;
            zero_q  <= 1'b0;
            nar_q   <= 1'b0;
            sr_q    <= abs_w << 1;
            pol_q   <= abs_w[N-2];
            r_q     <= '0;
            c_q     <= '0;
            state_q <= S_REGIME;
          end
        end
        S_REGIME: begin
          sr_q <= sr_q << 1;
          c_q  <= c_q + ONE;
          r_q  <= r_fin;
          if (regime_end) begin
            k_q     <= k_fin;
            state_q <= S_EXP;
          end
        end
        S_EXP: begin
          exp_q   <= exp_field;
          sr_q    <= sr_after_exp;
          state_q <= S_FRAC;
        end
        S_FRAC: begin
          mant_q      <= {1'b1, sr_q[N-1:1]};
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign sign        = sign_q;
  assign k           = k_q;
  assign exp         = exp_q;
  assign mantissa    = mant_q;
  assign zero        = zero_q;
  assign nar         = nar_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_posit_decoder_param.sv
// Bench for posit_decoder_param: a 32/3 instance driven from a vector table and
// random posits, plus a 16/1 instance for the small-width minpos case.
module tb_posit_decoder_param;

  localparam int N   = 32;
  localparam int ES  = 3;
  localparam int KW  = $clog2(N) + 1;
  localparam int EW  = ES;
  localparam int N2  = 16;
  localparam int ES2 = 1;
  localparam int KW2 = $clog2(N2) + 1;
  localparam int EW2 = ES2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  posit_in, mantissa;
  logic          sign, zero, nar;
  logic [KW-1:0] k;
  logic [EW-1:0] exp_o;
  logic [2:0]    dbg_state;

  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [N2-1:0]  s_posit_in, s_mantissa;
  logic           s_sign, s_zero, s_nar;
  logic [KW2-1:0] s_k;
  logic [EW2-1:0] s_exp;
  logic [2:0]     s_dbg_state;

  posit_decoder_param #(.N(N), .ES(ES)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .posit_in(posit_in), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .k(k), .exp(exp_o), .mantissa(mantissa), .zero(zero),
    .nar(nar), .dbg_state_o(dbg_state)
  );

  posit_decoder_param #(.N(N2), .ES(ES2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .posit_in(s_posit_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sign(s_sign), .k(s_k), .exp(s_exp), .mantissa(s_mantissa), .zero(s_zero),
    .nar(s_nar), .dbg_state_o(s_dbg_state)
  );

  typedef struct {
    logic [63:0] p;
    logic        zero;
    logic        nar;
    logic        sign;
    int          k;
    int          e;
    logic [63:0] mant;
    int          lat;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: decode the posit from its bit-level definition in n-bit arithmetic.
  function automatic vec_t ref_decode(input int n, input int es, input logic [63:0] p);
    vec_t v;
    logic [63:0] mask, a, rest, fr;
    logic first;
    int r, i, m;
    v = '{default: 0};
    v.p = p;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (p == 64'd0) begin v.zero = 1'b1; v.lat = 2; return v; end
    if (p == (64'd1 << (n - 1))) begin v.nar = 1'b1; v.lat = 2; return v; end
    v.sign = p[n-1];
    a = v.sign ? ((~p + 64'd1) & mask) : p;
    first = a[n-2];
    r = 0;
    i = n - 2;
    while (i >= 0 && a[i] == first) begin r++; i--; end
    m = (r + 1 < n - 1) ? r + 1 : n - 1;
    v.k = first ? r - 1 : -r;
    rest = (a << (m + 1)) & mask;
    v.e = (es == 0) ? 0 : int'(rest >> (n - es));
    fr = (rest << es) & mask;
    v.mant = (64'd1 << (n - 1)) | (fr >> 1);
    v.lat = m + 4;
    return v;
  endfunction

  task automatic run32(input vec_t v, input int hold);
    int lat;
    logic [N+KW+EW+2:0] snap;
    @(negedge clk);
    in_valid = 1'b1;
    posit_in = v.p[N-1:0];
    out_ready = 1'b0;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    posit_in = $urandom();
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    chk("latency", 64'(lat), 64'(v.lat));
    chk("zero", 64'(zero), 64'(v.zero));
    chk("nar", 64'(nar), 64'(v.nar));
    if (!v.zero && !v.nar) begin
      chk("sign", 64'(sign), 64'(v.sign));
      chk("k", 64'(longint'($signed(k))), 64'(longint'(v.k)));
      chk("exp", 64'(exp_o), 64'(v.e));
      chk("mantissa", 64'(mantissa), v.mant);
    end
    snap = {sign, k, exp_o, mantissa, zero, nar};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_stable", 64'({sign, k, exp_o, mantissa, zero, nar}), 64'(snap));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_keep", 64'({sign, k, exp_o, mantissa, zero, nar}), 64'(snap));
  endtask

  task automatic run16(input vec_t v);
    int lat;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_posit_in = v.p[N2-1:0];
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_out_valid && lat < 100);
    chk("n16_latency", 64'(lat), 64'(v.lat));
    chk("n16_zero", 64'(s_zero), 64'(v.zero));
    chk("n16_nar", 64'(s_nar), 64'(v.nar));
    if (!v.zero && !v.nar) begin
      chk("n16_sign", 64'(s_sign), 64'(v.sign));
      chk("n16_k", 64'(longint'($signed(s_k))), 64'(longint'(v.k)));
      chk("n16_exp", 64'(s_exp), 64'(v.e));
      chk("n16_mantissa", 64'(s_mantissa), v.mant);
    end
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    logic [63:0] p;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    posit_in = '0;
    s_in_valid = 1'b0;
    s_out_ready = 1'b0;
    s_posit_in = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({out_valid, sign, k, exp_o, mantissa, zero, nar}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //          p             zero  nar   sign  k    e  mant           lat
    tbl[0] = '{64'h00000000, 1'b1, 1'b0, 1'b0,  0,  0, 64'h0,          2};
    tbl[1] = '{64'h80000000, 1'b0, 1'b1, 1'b0,  0,  0, 64'h0,          2};
    tbl[2] = '{64'h5A000000, 1'b0, 1'b0, 1'b0,  0,  6, 64'hC0000000,   6};
    tbl[3] = '{64'hC0000000, 1'b0, 1'b0, 1'b1,  0,  0, 64'h80000000,   6};
    tbl[4] = '{64'h7FFFFFFF, 1'b0, 1'b0, 1'b0,  30, 0, 64'h80000000,  35};
    tbl[5] = '{64'h00000001, 1'b0, 1'b0, 1'b0, -30, 0, 64'h80000000,  35};
    tbl[6] = '{64'hFFFFFFFF, 1'b0, 1'b0, 1'b1, -30, 0, 64'h80000000,  35};
    tbl[7] = '{64'h0C000000, 1'b0, 1'b0, 1'b0, -3,  4, 64'h80000000,   8};
    tbl[8] = '{64'h7FFFFFFB, 1'b0, 1'b0, 1'b0,  27, 6, 64'h80000000,  33};
    for (int i = 0; i < 9; i++) run32(tbl[i], (i == 2) ? 5 : 0);

    for (int i = 0; i < 40; i++) begin
      p = 64'($urandom());
      if (i % 3 == 1) p = p >> $urandom_range(0, 31);
      if (i % 5 == 2) p = (~p) & 64'hFFFFFFFF;
      run32(ref_decode(N, ES, p), $urandom_range(0, 3));
    end

    // Abort a long decode mid-regime; nothing may emerge and outputs clear at once.
    @(negedge clk);
    in_valid = 1'b1;
    posit_in = 32'h7FFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_outputs", 64'({out_valid, sign, k, exp_o, mantissa, zero, nar}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    run32(ref_decode(N, ES, 64'h5A000000), 1);

    v = ref_decode(N2, ES2, 64'h0001);
    chk("n16_minpos_model_k", 64'(longint'(v.k)), 64'(longint'(-14)));
    run16(v);
    run16(ref_decode(N2, ES2, 64'h0000));
    run16(ref_decode(N2, ES2, 64'h8000));
    for (int i = 0; i < 8; i++) run16(ref_decode(N2, ES2, 64'($urandom_range(0, 65535))));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/posit_decoder_param.md
Name: posit_decoder_param

Overview:
- Parametrised, handshaked successor to the team's fixed 32-bit posit decoder.
- Decodes an N-bit posit with ES exponent bits into sign, signed regime k, exponent and a hidden-bit-normalised mantissa, with zero and NaR flags.
- New behaviour:
  - Negative posits are two's-complemented before the regime is decoded.
  - A valid/ready handshake on both sides supports back-pressure.
  - Width and ES are generic.
- Sits ahead of the posit arithmetic datapath (mult/add), feeding its unpack stage.

Parameters:
- N, 32: posit width in bits. Legal range 8..64.
- ES, 3: exponent field width in bits. Legal range 0..4.
- KW, $clog2(N)+1: derived localparam. Width of the signed k output.
- EW, (ES==0)?1:ES: derived localparam. Width of the exp output.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  posit_in is valid
- in_ready  output  1  block can accept a posit
- posit_in  input  N  posit to decode
- out_valid  output  1  decoded result is valid
- out_ready  input  1  consumer accepts the result
- sign  output  1  sign bit of posit_in
- k  output  KW  signed regime value
- exp  output  EW  exponent field value
- mantissa  output  N  {1'b1, fraction bits left-aligned, zero-padded}
- zero  output  1  input was all zeros
- nar  output  1  input was 1 followed by all zeros

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While rst is high, the block is in state IDLE and all of the following are 0: out_valid, sign, k, exp, mantissa, zero, nar, and the internal shift register and counters. in_ready is 1.
- in_ready is a registered-state decode: high only in IDLE.
- States: IDLE, PREP, REGIME, EXP, FRAC, DONE.
- IDLE:
  - On in_valid && in_ready, latch posit_in and go to PREP.
- PREP:
  - If the latched word is 0: zero=1, nar=0, go to DONE.
  - If the latched word is 1<<(N-1): nar=1, zero=0, go to DONE.
  - Otherwise:
    - sign = MSB.
    - If sign=1, replace the word with its two's complement.
    - Clear zero and nar.
    - Load shift register sr with word<<1.
    - Go to REGIME.
- REGIME:
  - Consumes one bit per cycle from sr[N-1], shifting left by 1 each cycle.
  - The first bit sets the run polarity.
  - Identical bits increment the run count r.
  - The first opposite bit is the terminator: consume it, then go to EXP.
  - If N-1 bits are consumed with no terminator, go to EXP with r=N-1.
  - m = number of REGIME cycles = min(r+1, N-1).
  - k = r-1 for a run of ones; k = -r for a run of zeros.
  - k is written on exit from REGIME.
- EXP:
  - exp = sr[N-1 -: ES]; sr <<= ES.
  - Bits already shifted out read as 0, so a truncated exponent is zero-filled in its LSBs.
  - If ES=0, exp=0 and no shift occurs.
  - EXP always takes 1 cycle.
- FRAC:
  - mantissa = {1'b1, sr[N-1:1]}.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - All outputs are held stable until out_ready=1.
  - On out_ready=1, go to IDLE; out_valid drops in the next cycle.
- Latency, counted from the accepting clock edge to the first cycle with out_valid=1:
  - Normal input: m+4 cycles.
  - zero or NaR: 2 cycles.
- Result outputs keep their last values after the handshake until the next decode overwrites them.
- in_valid is ignored outside IDLE.
- Back-to-back transfers: the earliest next accept is the cycle after the DONE handshake (IDLE).
- Reset asserted in any state aborts the decode. out_valid does not pulse, and all outputs return to their reset values asynchronously.
- There is no signed overflow on k: KW bits cover the range [-(N-1), N-2].

Test Plan:
- N=32, ES=3, posit 0x00000000 -> zero=1, nar=0, out_valid 2 cycles after accept.
- posit 0x80000000 -> nar=1, zero=0.
- posit 0x5A000000 -> sign=0, k=0, exp=6, mantissa=0xC0000000, m=2, out_valid at cycle 6.
- posit 0xC0000000 (-1.0) -> two's complement path, sign=1, k=0, exp=0, mantissa=0x80000000.
- posit 0x7FFFFFFF (maxpos) -> k=30, exp=0, mantissa=0x80000000, m=31.
- N=16, ES=1 rebuild, posit 0x0001 (minpos) -> k=-14, exp=0, mantissa=0x8000, m=15.
- Back-pressure: hold out_ready low 5 cycles in DONE -> outputs stable and in_ready=0; on release, in_ready=1 the next cycle.
- Reset mid-decode: assert rst during REGIME -> out_valid never asserts, all outputs 0, in_ready=1, and the next decode is correct.
